// File: rtl/permute_wb_scatter.sv
// -----------------------------------------------------------------------------
// permute_wb_scatter
//   Registered write-back scatter. One input beat carries N lane results and a
//   per-lane target bank. Each lane is routed to out_data_bus[bank] with a
//   per-bank write enable. When several lanes target the same bank, the lowest
//   lane wins the current pass and the rest are replayed on extra beats.
//   Every accepted beat produces at least one output beat, including a beat
//   with no live lanes.
//
// Optional feature macro: PERMUTE_WB_STATS_EN
//   defined   : conflict_cnt counts replay passes, saturating at 16'hFFFF
//   undefined : conflict_cnt is tied to zero; routing is unchanged
//
// Ports
//   clk           in   1       clock
//   rst           in   1       asynchronous, active-high reset
//   in_valid      in   1       input beat valid
//   in_ready      out  1       input beat accepted when in_valid && in_ready
//   in_data_bus   in   N*W     lane j data at [j*W +: W]
//   in_sel_bus    in   N*SELW  lane j target bank at [j*SELW +: SELW]
//   in_mask       in   N       lane j participates when in_mask[j] = 1
//   out_valid     out  1       output beat valid
//   out_ready     in   1       downstream accepts output beat
//   out_data_bus  out  N*W     bank m data at [m*W +: W]
//   out_we        out  N       bank m write enable
//   err_range     out  1       sticky: a masked-in lane had sel >= N
//   conflict_cnt  out  16      replay passes caused by bank collisions
// -----------------------------------------------------------------------------
module permute_wb_scatter #(
  parameter int N    = 4,   // lanes == banks
  parameter int W    = 12,  // data width per lane
  parameter int SELW = 2    // bank-index width per lane
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*W-1:0]  in_data_bus,
  input  logic [N*SELW-1:0] in_sel_bus,
  input  logic [N-1:0]    in_mask,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*W-1:0]  out_data_bus,
  output logic [N-1:0]    out_we,
  output logic            err_range,
  output logic [15:0]     conflict_cnt
);

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  state_t              state_q, state_d;

  // Held copy of the accepted beat, replayed from while draining collisions.
  logic [N*W-1:0]      held_data_q;
  logic [N*SELW-1:0]   held_sel_q;
  logic [N-1:0]        pending_q;

  logic                out_free;
  logic                accept;
  logic                drain_load;
  logic                load;

  logic [N-1:0]        sel_ok;
  logic [N-1:0]        live_in;

  // Pass source: the incoming beat while idle, the held beat while draining.
  logic [N*W-1:0]      src_data;
  logic [N*SELW-1:0]   src_sel;
  logic [N-1:0]        src_live;

  logic [N*W-1:0]      pass_data;
  logic [N-1:0]        pass_we;
  logic [N-1:0]        pass_chosen;
  logic [N-1:0]        pass_rem;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  assign out_free   = !out_valid || out_ready;
  assign in_ready   = (state_q == IDLE) && out_free;
  assign accept     = in_valid && in_ready;
  assign drain_load = (state_q == DRAIN) && out_free;
  assign load       = accept || drain_load;

  // ---------------------------------------------------------------------------
  // Range check of incoming selectors; out-of-range lanes are dropped.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    sel_ok  = '0;
    live_in = '0;
    for (int j = 0; j < N; j++) begin
      sel_ok[j]  = int'(in_sel_bus[j*SELW +: SELW]) < N;
      live_in[j] = in_mask[j] && sel_ok[j];
    end
  end

  // ---------------------------------------------------------------------------
  // One routing pass: each bank takes the lowest live lane that targets it.
  // ---------------------------------------------------------------------------
  always_comb begin
    src_data    = (state_q == IDLE) ? in_data_bus : held_data_q;
    src_sel     = (state_q == IDLE) ? in_sel_bus  : held_sel_q;
    src_live    = (state_q == IDLE) ? live_in     : pending_q;
    pass_data   = '0;
    pass_we     = '0;
    pass_chosen = '0;
    for (int m = 0; m < N; m++) begin
      for (int j = 0; j < N; j++) begin
        // Ascending lane order plus the !pass_we guard gives lowest-lane priority.
        if (!pass_we[m] && src_live[j] && (int'(src_sel[j*SELW +: SELW]) == m)) begin
          pass_we[m]            = 1'b1;
          pass_data[m*W +: W]   = src_data[j*W +: W];
          pass_chosen[j]        = 1'b1;
        end
      end
    end
    pass_rem = src_live & ~pass_chosen;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && (pass_rem != '0)) state_d = DRAIN;
      DRAIN:   if (drain_load && (pass_rem == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, held beat and output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      // NOTE: the held beat is a handful of flops rather than a RAM, so it is
      // reset along with the control state; nothing stale survives a reset.
      held_data_q  <= '0;
      held_sel_q   <= '0;
      pending_q    <= '0;
      out_valid    <= 1'b0;
      out_we       <= '0;
      out_data_bus <= '0;
      err_range    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;

      if (accept) begin
        held_data_q <= in_data_bus;
        held_sel_q  <= in_sel_bus;
        if ((in_mask & ~sel_ok) != '0) err_range <= 1'b1;
      end

      if (load) begin
        out_valid    <= 1'b1;
        out_we       <= pass_we;
        out_data_bus <= pass_data;
        pending_q    <= pass_rem;
      end else if (out_ready) begin
        // Beat consumed with nothing to replace it; drop the enables too so a
        // stale write strobe never lingers behind a low valid.
        out_valid <= 1'b0;
        out_we    <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Collision statistics
  // ---------------------------------------------------------------------------
`ifdef PERMUTE_WB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (drain_load && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_permute_wb_scatter.sv
// -----------------------------------------------------------------------------
// tb_permute_wb_scatter
//   Directed and randomized bench for permute_wb_scatter. The expected output
//   beats are derived from lane rank: a live lane that is the k-th lane (in
//   index order) aimed at its bank appears in output beat k. A beat yields
//   max(1, largest per-bank lane count) output beats.
// -----------------------------------------------------------------------------
module tb_permute_wb_scatter;

  localparam int N    = 4;
  localparam int W    = 12;
  localparam int SELW = 2;

  localparam int N3    = 3;
  localparam int SELW3 = 2;

  logic                clk = 1'b0;
  logic                rst;

  logic                in_valid;
  logic                in_ready;
  logic [N*W-1:0]      in_data_bus;
  logic [N*SELW-1:0]   in_sel_bus;
  logic [N-1:0]        in_mask;
  logic                out_valid;
  logic                out_ready;
  logic [N*W-1:0]      out_data_bus;
  logic [N-1:0]        out_we;
  logic                err_range;
  logic [15:0]         conflict_cnt;

  logic                in3_valid;
  logic                in3_ready;
  logic [N3*W-1:0]     in3_data_bus;
  logic [N3*SELW3-1:0] in3_sel_bus;
  logic [N3-1:0]       in3_mask;
  logic                out3_valid;
  logic [N3*W-1:0]     out3_data_bus;
  logic [N3-1:0]       out3_we;
  logic                err3_range;
  logic [15:0]         conflict3_cnt;

  always #5 clk = ~clk;

  permute_wb_scatter #(.N(N), .W(W), .SELW(SELW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data_bus  (in_data_bus),
    .in_sel_bus   (in_sel_bus),
    .in_mask      (in_mask),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data_bus (out_data_bus),
    .out_we       (out_we),
    .err_range    (err_range),
    .conflict_cnt (conflict_cnt)
  );

  permute_wb_scatter #(.N(N3), .W(W), .SELW(SELW3)) dut3 (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in3_valid),
    .in_ready     (in3_ready),
    .in_data_bus  (in3_data_bus),
    .in_sel_bus   (in3_sel_bus),
    .in_mask      (in3_mask),
    .out_valid    (out3_valid),
    .out_ready    (1'b1),
    .out_data_bus (out3_data_bus),
    .out_we       (out3_we),
    .err_range    (err3_range),
    .conflict_cnt (conflict3_cnt)
  );

  typedef struct {
    logic [N-1:0]   we;
    logic [N*W-1:0] data;
  } beat_t;

  beat_t q[$];
  int    n_asserts = 0;
  int    n_fail    = 0;
  int    conflicts = 0;
  int    out_count = 0;
  bit    accepted  = 0;
  bit    rnd_ready = 0;

  localparam logic [W-1:0] DA = 12'hA0A, DB = 12'hB0B, DC = 12'hC0C, DD = 12'hD0D;
  localparam logic [N*SELW-1:0] SEL_ID = {2'd3, 2'd2, 2'd1, 2'd0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_cnt();
`ifdef PERMUTE_WB_STATS_EN
    return (conflicts > 65535) ? 65535 : conflicts;
`else
    return 0;
`endif
  endfunction

  // Reference model: output beat index of a lane = its rank among earlier
  // live lanes aimed at the same bank.
  task automatic push_expected(input logic [N*W-1:0] d, input logic [N*SELW-1:0] s,
                               input logic [N-1:0] m);
    int    rank [N];
    int    tgt  [N];
    bit    live [N];
    int    nb = 1;
    beat_t b;
    for (int j = 0; j < N; j++) begin
      tgt[j]  = int'(s[j*SELW +: SELW]);
      live[j] = m[j] && (tgt[j] < N);
      rank[j] = 0;
      for (int i = 0; i < j; i++)
        if (live[i] && tgt[i] == tgt[j]) rank[j]++;
      if (live[j] && rank[j] + 1 > nb) nb = rank[j] + 1;
    end
    for (int k = 0; k < nb; k++) begin
      b.we   = '0;
      b.data = '0;
      for (int j = 0; j < N; j++) begin
        if (live[j] && rank[j] == k) begin
          b.we[tgt[j]]            = 1'b1;
          b.data[tgt[j]*W +: W]   = d[j*W +: W];
        end
      end
      q.push_back(b);
    end
    conflicts += nb - 1;
  endtask

  // One clock: checks at the falling edge, then returns 1 time unit after the
  // rising edge, where new stimulus is applied.
  task automatic cycle();
    beat_t b;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'((q.size() == 0) || (q.size() == 1 && out_ready)));
    if (out_valid && out_ready && q.size() > 0) begin
      b = q.pop_front();
      chk("out_we", 64'(out_we), 64'(b.we));
      chk("out_data", 64'(out_data_bus), 64'(b.data));
      out_count++;
    end
    if (in_valid && in_ready) begin
      push_expected(in_data_bus, in_sel_bus, in_mask);
      accepted = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N*W-1:0] d, input logic [N*SELW-1:0] s,
                      input logic [N-1:0] m);
    in_valid    = 1'b1;
    in_data_bus = d;
    in_sel_bus  = s;
    in_mask     = m;
    accepted    = 0;
    for (int i = 0; i < 100 && !accepted; i++) cycle();
    chk("accept_timeout", 64'(accepted), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() != 0; i++) cycle();
    chk("drain_timeout", 64'(q.size()), 64'(0));
  endtask

  initial begin
    logic [N*W-1:0]    d;
    logic [N*SELW-1:0] s;

    rst          = 1'b1;
    in_valid     = 1'b0;
    in_data_bus  = '0;
    in_sel_bus   = '0;
    in_mask      = '0;
    out_ready    = 1'b1;
    in3_valid    = 1'b0;
    in3_data_bus = '0;
    in3_sel_bus  = '0;
    in3_mask     = '0;

    // Reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_we", 64'(out_we), 64'(0));
    chk("rst_out_data", 64'(out_data_bus), 64'(0));
    chk("rst_err", 64'(err_range), 64'(0));
    chk("rst_cnt", 64'(conflict_cnt), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // T1: identity routing, one beat one cycle after accept
    send({DD, DC, DB, DA}, SEL_ID, 4'hF);
    chk("t1_valid", 64'(out_valid), 64'(1));
    chk("t1_we", 64'(out_we), 64'(4'hF));
    chk("t1_data", 64'(out_data_bus), 64'({DD, DC, DB, DA}));
    drain();

    // T2: reversed routing held under backpressure
    out_ready = 1'b0;
    send({DD, DC, DB, DA}, {2'd0, 2'd1, 2'd2, 2'd3}, 4'hF);
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold_data", 64'(out_data_bus), 64'({DA, DB, DC, DD}));
      chk("t2_hold_we", 64'(out_we), 64'(4'hF));
      chk("t2_in_ready", 64'(in_ready), 64'(0));
      cycle();
    end
    out_ready = 1'b1;
    drain();

    // T3: pairwise collisions split over two beats
    send({DD, DC, DB, DA}, {2'd1, 2'd1, 2'd0, 2'd0}, 4'hF);
    chk("t3_in_ready_drain", 64'(in_ready), 64'(0));
    chk("t3_we1", 64'(out_we), 64'(4'b0011));
    chk("t3_data1", 64'(out_data_bus), 64'({12'h0, 12'h0, DC, DA}));
    drain();
    cycle();
    chk("t3_cnt", 64'(conflict_cnt), 64'(exp_cnt()));

    // T5: reset in the middle of a 4-beat drain
    send({DD, DC, DB, DA}, '0, 4'hF);
    cycle();
    rst = 1'b1;
    #1;
    chk("t5_valid", 64'(out_valid), 64'(0));
    chk("t5_we", 64'(out_we), 64'(0));
    chk("t5_cnt", 64'(conflict_cnt), 64'(0));
    q.delete();
    conflicts = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send({DD, DC, DB, DA}, SEL_ID, 4'hF);
    chk("t5_id_we", 64'(out_we), 64'(4'hF));
    chk("t5_id_data", 64'(out_data_bus), 64'({DD, DC, DB, DA}));
    drain();

    // T4: three-lane instance, lane 1 aimed past the last bank
    in3_valid    = 1'b1;
    in3_data_bus = {DC, DB, DA};
    in3_sel_bus  = {2'd2, 2'd3, 2'd0};
    in3_mask     = 3'b111;
    @(posedge clk);
    #1;
    in3_valid = 1'b0;
    chk("t4_valid", 64'(out3_valid), 64'(1));
    chk("t4_we", 64'(out3_we), 64'(3'b101));
    chk("t4_data", 64'(out3_data_bus), 64'({DC, 12'h0, DA}));
    chk("t4_err", 64'(err3_range), 64'(1));
    @(posedge clk);
    #1;
    in3_valid   = 1'b1;
    in3_sel_bus = {2'd2, 2'd1, 2'd0};
    @(posedge clk);
    #1;
    in3_valid = 1'b0;
    chk("t4_we2", 64'(out3_we), 64'(3'b111));
    chk("t4_err_sticky", 64'(err3_range), 64'(1));

    // T6: eight back-to-back identity beats
    out_count = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid    = 1'b1;
      in_data_bus = N*W'($urandom()) ^ {N{W'(i)}};
      in_sel_bus  = SEL_ID;
      in_mask     = 4'hF;
      accepted    = 0;
      cycle();
      chk("t6_accept", 64'(accepted), 64'(1));
    end
    in_valid = 1'b0;
    cycle();
    chk("t6_beats", 64'(out_count), 64'(8));
    chk("t6_cnt", 64'(conflict_cnt), 64'(exp_cnt()));

    // Random beats with random downstream backpressure
    rnd_ready = 1;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) cycle();
      d = {W'($urandom()), W'($urandom()), W'($urandom()), W'($urandom())};
      s = (N*SELW)'($urandom());
      send(d, s, N'($urandom_range(0, 15)));
    end
    drain();
    rnd_ready = 0;
    out_ready = 1'b1;
    cycle();
    chk("rnd_cnt", 64'(conflict_cnt), 64'(exp_cnt()));
    chk("rnd_err", 64'(err_range), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
